// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor: gate-window frequency/presence checker for a clock sampled as data in the sys_clk domain
//   sys_clk    in        system clock, all logic on its rising edge
//   reset_n    in        synchronous active-low reset
//   enable     in        1 = measure, 0 = hold in reset-equivalent state
//   mon_clk    in        monitored clock, asynchronous, below sys_clk/2
//   freq_count out [CW]  edge count of the last completed window
//   meas_valid out       one-cycle pulse when freq_count updates
//   in_band    out       last count within [EXPECTED-TOL, EXPECTED+TOL]
//   locked     out       LOCK_CNT consecutive in-band windows seen
//   clk_lost   out       last window had zero edges
module clk_freq_monitor #(
   parameter int WINDOW   = 27000,
   parameter int EXPECTED = 6000,
   parameter int TOL      = 60,
   parameter int LOCK_CNT = 4,
   parameter int CW       = 16
) (
   input  logic          sys_clk,
   input  logic          reset_n,
   input  logic          enable,
   input  logic          mon_clk,
   output logic [CW-1:0] freq_count,
   output logic          meas_valid,
   output logic          in_band,
   output logic          locked,
   output logic          clk_lost
);
   localparam int TW = $clog2(WINDOW + 1);
   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int LO_I = (EXPECTED > TOL) ? EXPECTED - TOL : 0;
   localparam logic [CW:0] LO = (CW+1)'(LO_I);
   localparam logic [CW:0] HI = (CW+1)'(EXPECTED + TOL);
   typedef enum logic {ACQUIRE, LOCKED} state_t;
   state_t        state;
   logic [2:0]    sh;
   logic [TW-1:0] timer;
   logic [CW-1:0] cnt, total;
   logic [CW:0]   sum;
   logic [GW-1:0] good_cnt, good_nxt;
   logic          run, edge_det, tc, band;
   assign run      = reset_n & enable;
   assign edge_det = sh[1] & ~sh[2];
   assign tc       = timer == TW'(WINDOW - 1);
   // total already folds in a terminal-cycle edge, so the closing window owns it
   assign sum      = {1'b0, cnt} + (CW+1)'(edge_det);
   assign total    = sum[CW] ? '1 : sum[CW-1:0];
   assign band     = ({1'b0, total} >= LO) && ({1'b0, total} <= HI);
   assign good_nxt = (good_cnt == GW'(LOCK_CNT)) ? good_cnt : good_cnt + 1'b1;
   always_ff @(posedge sys_clk)
      if (!run) begin
         sh         <= '0;
         timer      <= '0;
         cnt        <= '0;
         good_cnt   <= '0;
         state      <= ACQUIRE;
         freq_count <= '0;
         meas_valid <= 1'b0;
         in_band    <= 1'b0;
         locked     <= 1'b0;
         clk_lost   <= 1'b0;
      end else begin
         sh         <= {sh[1:0], mon_clk};
         meas_valid <= tc;
         timer      <= tc ? '0 : timer + 1'b1;
         cnt        <= tc ? '0 : total;
         if (tc) begin
            freq_count <= total;
            in_band    <= band;
            clk_lost   <= total == '0;
            if (!band) begin
               state    <= ACQUIRE;
               good_cnt <= '0;
               locked   <= 1'b0;
            end else if (state == ACQUIRE) begin
               good_cnt <= good_nxt;
               if (good_nxt >= GW'(LOCK_CNT)) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
               end
            end
         end
      end
endmodule
